// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU requests, drives the datapath load/opcode inputs and returns captured results.
// Optional OP_COUNT_EN adds a response-handshake counter (op_count) with a clear input (count_clr).
module alu_op_sequencer #(
    parameter int DATA_W    = 8,
    parameter int REQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic [DATA_W-1:0] dp_data_a,
    output logic [DATA_W-1:0] dp_data_b,
    output logic              dp_load_a,
    output logic              dp_load_b,
    output logic [1:0]        dp_alu_op,
    input  logic [DATA_W-1:0] dp_result,
    input  logic              dp_zero,
    input  logic              dp_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              busy
`ifdef OP_COUNT_EN
    ,
    input  logic              count_clr,
    output logic [15:0]       op_count
`endif
);
    localparam int PW = $clog2(REQ_DEPTH);
    localparam int EW = 2 * DATA_W + 2;

    typedef enum logic [1:0] {IDLE, LOAD, EVAL, RESP} state_t;

    state_t            state, next;
    logic [EW-1:0]     mem [REQ_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              full, empty, push, pop, hs;
    logic [DATA_W-1:0] work_a, work_b;
    logic [1:0]        work_op;

    assign full      = count == (PW+1)'(REQ_DEPTH);
    assign empty     = count == '0;
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign hs        = rsp_valid && rsp_ready;
    assign busy      = !empty || state != IDLE;
    assign dp_data_a = work_a;
    assign dp_data_b = work_b;
    assign dp_alu_op = work_op;

    always_comb begin
        next      = state;
        pop       = 1'b0;
        dp_load_a = 1'b0;
        dp_load_b = 1'b0;
        case (state)
            IDLE: begin
                pop  = !empty;
                next = empty ? IDLE : LOAD;
            end
            LOAD: begin
                dp_load_a = 1'b1;
                dp_load_b = 1'b1;
                next      = EVAL;
            end
            EVAL: next = RESP;
            RESP: if (hs) begin
                pop  = !empty;
                next = empty ? IDLE : LOAD;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // A full queue never accepts, so push and pop never collide on the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < REQ_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_a, req_b, req_op};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_a  <= '0;
            work_b  <= '0;
            work_op <= '0;
        end else if (pop) begin
            {work_a, work_b, work_op} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else if (state == EVAL) begin
            rsp_valid  <= 1'b1;
            rsp_result <= dp_result;
            rsp_zero   <= dp_zero;
            rsp_carry  <= dp_carry;
        end else if (hs) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef OP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count <= '0;
        else        op_count <= count_clr ? 16'd0 : hs ? op_count + 16'd1 : op_count;
    end
`endif

endmodule
